// File: rtl/mem_master.sv
// mem_master: single-request load/store initiator for the data memory port.
// Ports: clk, rst (async, active-high); req/op/addr/wdata request side;
// ready/done/rdata/err response side; adr/mem_wdata/mrd/mwr/mem_rdata
// memory side. Optional misalignment trap enabled by ALIGN_CHECK_EN.
module mem_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] adr,
  output logic [31:0] mem_wdata,
  output logic        mrd,
  output logic        mwr,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  // Holds store data; for SH/SB it is overwritten with the merged word.
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] ld_val;
  logic [31:0] mrg_val;
  logic        mis;
  logic        is_store;

  always_comb begin
    ld_val = mem_rdata;
    case (op_q)
      OP_LH:   ld_val = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      OP_LHU:  ld_val = {16'h0, mem_rdata[15:0]};
      OP_LB:   ld_val = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      OP_LBU:  ld_val = {24'h0, mem_rdata[7:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    if (op_q == OP_SH) begin
      mrg_val = {mem_rdata[31:16], wdata_q[15:0]};
    end else begin
      mrg_val = {mem_rdata[31:8], wdata_q[7:0]};
    end
  end

  assign is_store = (op_q == OP_SW) || (op_q == OP_SH)
                 || (op_q == OP_SB);

`ifdef ALIGN_CHECK_EN
  always_comb begin
    case (op)
      OP_LW, OP_SW:         mis = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = addr[0];
      default:              mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = mis;
          if (mis) begin
            rdata_d = 32'h0;
            state_d = S_DONE;
          end else if (op == OP_SW) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (is_store) begin
          wdata_d = mrg_val;
          state_d = S_WR;
        end else begin
          rdata_d = ld_val;
          state_d = S_DONE;
        end
      end
      S_WR:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LW;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory-side outputs decode only from registered state.
  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mrd       = (state_q == S_RD);
  assign mwr       = (state_q == S_WR);
  assign adr       = (mrd || mwr) ? addr_q : 32'h0;
  assign mem_wdata = mwr ? wdata_q : 32'h0;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed bench for mem_master with a byte memory model.
// Checks handshake timing, extension, RMW merge, reset abort, alignment.
module tb_mem_master;

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LB  = 3'b011;
  localparam logic [2:0] SW  = 3'b101;
  localparam logic [2:0] SH  = 3'b110;
  localparam logic [2:0] SB  = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] adr;
  logic [31:0] mem_wdata;
  logic        mrd;
  logic        mwr;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int mwr_tot = 0;
  int done_tot = 0;

  logic [7:0] mem [0:65535];

  mem_master dut (
    .clk(clk), .rst(rst), .req(req), .op(op),
    .addr(addr), .wdata(wdata), .ready(ready),
    .done(done), .rdata(rdata), .err(err),
    .adr(adr), .mem_wdata(mem_wdata), .mrd(mrd),
    .mwr(mwr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ix(
    input logic [31:0] a, input logic [15:0] k);
    return a[15:0] + k;
  endfunction

  always_comb begin
    mem_rdata = 32'h0;
    if (mrd) begin
      mem_rdata = {mem[ix(adr, 16'd3)], mem[ix(adr, 16'd2)],
                   mem[ix(adr, 16'd1)], mem[ix(adr, 16'd0)]};
    end
  end

  always @(posedge clk) begin
    if (mwr) begin
      mem[ix(adr, 16'd0)] <= mem_wdata[7:0];
      mem[ix(adr, 16'd1)] <= mem_wdata[15:8];
      mem[ix(adr, 16'd2)] <= mem_wdata[23:16];
      mem[ix(adr, 16'd3)] <= mem_wdata[31:24];
      mwr_tot = mwr_tot + 1;
    end
    if (done) done_tot = done_tot + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdw(input logic [31:0] a);
    return {mem[ix(a, 16'd3)], mem[ix(a, 16'd2)],
            mem[ix(a, 16'd1)], mem[ix(a, 16'd0)]};
  endfunction

  task automatic setw(input logic [31:0] a, input logic [31:0] d);
    mem[ix(a, 16'd0)] = d[7:0];
    mem[ix(a, 16'd1)] = d[15:8];
    mem[ix(a, 16'd2)] = d[23:16];
    mem[ix(a, 16'd3)] = d[31:24];
  endtask

  // Issues one request and follows it until done (bounded).
  task automatic run(
    input  logic [2:0]  o,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  bit          hold,
    output int          done_c,
    output int          rd_c,
    output int          wr_c,
    output int          nrd,
    output int          nwr,
    output logic [31:0] rd_adr,
    output logic [31:0] wr_adr,
    output logic [31:0] wr_dat);
    done_c = -1; rd_c = -1; wr_c = -1;
    nrd = 0; nwr = 0;
    rd_adr = 32'h0; wr_adr = 32'h0; wr_dat = 32'h0;
    @(negedge clk);
    chk("ready_at_req", {31'h0, ready}, 32'h1);
    req = 1'b1; op = o; addr = a; wdata = wd;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      addr  = ~a;
      wdata = ~wd;
      if (!hold || c >= 2) req = 1'b0;
      if (mrd && mwr) chk("rd_wr_both", 32'h1, 32'h0);
      if (mrd) begin
        nrd++;
        if (rd_c < 0) rd_c = c;
        rd_adr = adr;
      end
      if (mwr) begin
        nwr++;
        if (wr_c < 0) wr_c = c;
        wr_adr = adr;
        wr_dat = mem_wdata;
      end
      if (done) begin
        done_c = c;
        break;
      end
    end
  endtask

  int dc, rc, wc, nr, nw;
  logic [31:0] ra, wa, wdv;
  int m0, d0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b1; req = 1'b0; op = LW;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    chk("rst_mrd_mwr", {30'h0, mrd, mwr}, 32'h0);
    rst = 1'b0;

    setw(32'h2000, 32'h12345678);
    setw(32'h2004, 32'h0000FF80);

    // LW aligned
    run(LW, 32'h2000, 32'h0, 1'b0, dc, rc, wc, nr, nw, ra, wa, wdv);
    chk("lw_rd_cyc", rc, 1);
    chk("lw_rd_adr", ra, 32'h2000);
    chk("lw_nwr", nw, 0);
    chk("lw_done_cyc", dc, 2);
    chk("lw_rdata", rdata, 32'h12345678);
    chk("lw_idle_adr", adr, 32'h0);

    // LW at 2002: misaligned
    run(LW, 32'h2002, 32'h0, 1'b0, dc, rc, wc, nr, nw, ra, wa, wdv);
`ifdef ALIGN_CHECK_EN
    chk("mis_done_cyc", dc, 1);
    chk("mis_err", {31'h0, err}, 32'h1);
    chk("mis_rdata", rdata, 32'h0);
    chk("mis_nrd", nr, 0);
`else
    chk("mis_done_cyc", dc, 2);
    chk("mis_err", {31'h0, err}, 32'h0);
    chk("mis_rdata", rdata, 32'hFF801234);
    chk("mis_nrd", nr, 1);
`endif
    chk("mis_nwr", nw, 0);

    // Byte/half loads
    run(LB, 32'h2004, 32'h0, 1'b0, dc, rc, wc, nr, nw, ra, wa, wdv);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_err", {31'h0, err}, 32'h0);
    chk("lb_done_cyc", dc, 2);
    run(LBU, 32'h2004, 32'h0, 1'b0, dc, rc, wc, nr, nw, ra, wa, wdv);
    chk("lbu_rdata", rdata, 32'h00000080);
    run(LH, 32'h2004, 32'h0, 1'b0, dc, rc, wc, nr, nw, ra, wa, wdv);
    chk("lh_rdata", rdata, 32'hFFFFFF80);

    // SB read-modify-write
    setw(32'h2001, 32'h11223344);
    run(SB, 32'h2001, 32'hFFFFFFAB, 1'b0, dc, rc, wc, nr, nw,
        ra, wa, wdv);
    chk("sb_rd_cyc", rc, 1);
    chk("sb_rd_adr", ra, 32'h2001);
    chk("sb_wr_cyc", wc, 2);
    chk("sb_wr_adr", wa, 32'h2001);
    chk("sb_wr_dat", wdv, 32'h112233AB);
    chk("sb_done_cyc", dc, 3);
    chk("sb_rdata_kept", rdata, 32'hFFFFFF80);
    run(LW, 32'h2000, 32'h0, 1'b0, dc, rc, wc, nr, nw, ra, wa, wdv);
    chk("sb_readback", rdata, 32'h2233AB78);

    // SH read-modify-write
    setw(32'h2020, 32'hDDCCBBAA);
    run(SH, 32'h2020, 32'h12345678, 1'b0, dc, rc, wc, nr, nw,
        ra, wa, wdv);
    chk("sh_wr_dat", wdv, 32'hDDCC5678);
    chk("sh_done_cyc", dc, 3);
    chk("sh_mem", rdw(32'h2020), 32'hDDCC5678);

    // SW with req held over busy cycles
    m0 = mwr_tot;
    run(SW, 32'h2008, 32'hDEADBEEF, 1'b1, dc, rc, wc, nr, nw,
        ra, wa, wdv);
    chk("sw_wr_cyc", wc, 1);
    chk("sw_wr_adr", wa, 32'h2008);
    chk("sw_nrd", nr, 0);
    chk("sw_done_cyc", dc, 2);
    repeat (3) @(negedge clk);
    chk("sw_one_mwr", mwr_tot - m0, 1);
    chk("sw_ready_after", {31'h0, ready}, 32'h1);
    run(LW, 32'h2008, 32'h0, 1'b0, dc, rc, wc, nr, nw, ra, wa, wdv);
    chk("sw_readback", rdata, 32'hDEADBEEF);

    // Reset during RD of an SH
    setw(32'h2030, 32'h04030201);
    @(negedge clk);
    m0 = mwr_tot; d0 = done_tot;
    req = 1'b1; op = SH; addr = 32'h2030; wdata = 32'h5555;
    @(negedge clk);
    req = 1'b0;
    chk("abort_mrd", {31'h0, mrd}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("abort_mrd0", {31'h0, mrd}, 32'h0);
    chk("abort_adr", adr, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_mwr", mwr_tot - m0, 0);
    chk("abort_no_done", done_tot - d0, 0);
    chk("abort_mem", rdw(32'h2030), 32'h04030201);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
